// File: rtl/uart_axis_fifo.sv
// UART transceiver with AXI-Stream TX/RX FIFOs. Bit period is 8*prescale clocks.
// Parity generation/checking is built only when UART_AXIS_FIFO_PARITY_EN is defined.
module uart_axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          rxd,
  output logic                          txd,
  input  logic [15:0]                   prescale,
  output logic                          tx_busy,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_overrun,
  output logic                          rx_frame_error,
  output logic                          rx_parity_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 19;
  localparam int BW = 4;
  localparam logic [LW-1:0] FULL_LEVEL = FIFO_DEPTH[LW-1:0];
`ifdef UART_AXIS_FIFO_PARITY_EN
  localparam int PAR_MODE = PARITY;
`else
  // PARITY is ignored in this build; the frame never carries a parity bit.
  localparam int PAR_MODE = PARITY * 0;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [15:0] ps_eff;
  assign ps_eff = (prescale == 16'd0) ? 16'd1 : prescale;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr;
  logic                  tx_push, tx_pop, tx_empty, tx_full;

  assign tx_empty      = (tx_level == '0);
  assign tx_full       = (tx_level == FULL_LEVEL);
  assign s_axis_tready = !rst && !tx_full;
  assign tx_push       = s_axis_tvalid && s_axis_tready;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (tx_push && !tx_pop)      tx_level <= tx_level + LW'(1);
      else if (tx_pop && !tx_push) tx_level <= tx_level - LW'(1);
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= s_axis_tdata;
  end

  // ---------------- TX FSM ----------------
  tx_state_t             tx_state, tx_state_d;
  logic [CW-1:0]         tx_cnt;
  logic [BW-1:0]         tx_bit_idx;
  logic [DATA_WIDTH-1:0] tx_shift, tx_head;
  logic [15:0]           tx_ps;
  logic                  tx_par, tx_bit_end, tx_last_data, tx_last_stop;

  assign tx_head      = tx_mem[tx_rd_ptr];
  assign tx_bit_end   = (tx_cnt == {tx_ps, 3'b000} - CW'(1));
  assign tx_last_data = (tx_bit_idx == BW'(DATA_WIDTH - 1));
  assign tx_last_stop = (tx_bit_idx == BW'(STOP_BITS - 1));
  assign tx_busy      = (tx_state != TX_IDLE) || !tx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) tx_state_d = TX_START;
      TX_START:  if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_last_data) tx_state_d = (PAR_MODE != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_bit_end && tx_last_stop) tx_state_d = tx_empty ? TX_IDLE : TX_START;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    tx_pop = 1'b0;
    txd    = 1'b1;
    case (tx_state)
      TX_IDLE:   tx_pop = !tx_empty;
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shift[0];
      TX_PARITY: txd = tx_par;
      TX_STOP:   tx_pop = tx_bit_end && tx_last_stop && !tx_empty;
      default:   ;
    endcase
  end

  // A pop starts a frame: load the byte and freeze the bit period for its duration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_ps      <= 16'd1;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
    end else if (tx_pop) begin
      tx_shift   <= tx_head;
      tx_par     <= (PAR_MODE == 1) ? ~^tx_head : ^tx_head;
      tx_ps      <= ps_eff;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_shift   <= tx_shift >> 1;
          tx_bit_idx <= tx_last_data ? '0 : tx_bit_idx + BW'(1);
        end else if (tx_state == TX_STOP) begin
          tx_bit_idx <= tx_bit_idx + BW'(1);
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t             rx_state, rx_state_d;
  logic [1:0]            rx_sync;
  logic                  rx_prev, rxd_s, rx_fall;
  logic [CW-1:0]         rx_cnt;
  logic [BW-1:0]         rx_bit_idx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [15:0]           rx_ps;
  logic                  rx_par_bit, rx_par_exp, rx_half_end, rx_bit_end, rx_last_data;
  logic                  rx_push_req, rx_pop, rx_empty, rx_full;

  assign rxd_s        = rx_sync[1];
  assign rx_fall      = rx_prev && !rxd_s;
  assign rx_half_end  = (rx_cnt == {1'b0, rx_ps, 2'b00} - CW'(1));
  assign rx_bit_end   = (rx_cnt == {rx_ps, 3'b000} - CW'(1));
  assign rx_last_data = (rx_bit_idx == BW'(DATA_WIDTH - 1));
  assign rx_par_exp   = (PAR_MODE == 1) ? ~^rx_shift : ^rx_shift;
  assign rx_busy      = (rx_state != RX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_prev  <= rxd_s;
      rx_state <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_fall) rx_state_d = RX_START;
      RX_START:     if (rx_half_end) rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_bit_end && rx_last_data) rx_state_d = (PAR_MODE != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_bit_end) rx_state_d = RX_STOP;
      RX_STOP:      if (rx_bit_end) rx_state_d = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rxd_s) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req    = 1'b0;
    rx_frame_error = 1'b0;
    if (rx_state == RX_STOP && rx_bit_end) begin
      rx_push_req    = rxd_s;
      rx_frame_error = !rxd_s;
    end
  end

  assign rx_parity_error = (PAR_MODE != 0) && rx_push_req && (rx_par_bit != rx_par_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_ps      <= 16'd1;
      rx_par_bit <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      if (rx_fall) rx_ps <= ps_eff;
    end else if (rx_state != RX_WAIT_HIGH) begin
      if ((rx_state == RX_START) ? rx_half_end : rx_bit_end) begin
        rx_cnt <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift   <= {rxd_s, rx_shift[DATA_WIDTH-1:1]};
          rx_bit_idx <= rx_bit_idx + BW'(1);
        end
        if (rx_state == RX_PARITY) rx_par_bit <= rxd_s;
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_ptr, rx_rd_ptr;
  logic                  rx_wr_en;

  assign rx_empty      = (rx_level == '0);
  assign rx_full       = (rx_level == FULL_LEVEL);
  assign m_axis_tvalid = !rx_empty;
  assign m_axis_tdata  = rx_mem[rx_rd_ptr];
  assign rx_pop        = m_axis_tvalid && m_axis_tready;
  assign rx_wr_en      = rx_push_req && (!rx_full || rx_pop);
  assign rx_overrun    = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_wr_en) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (rx_wr_en && !rx_pop)      rx_level <= rx_level + LW'(1);
      else if (rx_pop && !rx_wr_en) rx_level <= rx_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr_ptr] <= rx_shift;
  end

endmodule

// File: tb/tb_uart_axis_fifo.sv
// Self-checking bench for uart_axis_fifo: TX bit timing, loopback, overrun, framing,
// parity (when UART_AXIS_FIFO_PARITY_EN is defined) and mid-frame reset.
module tb_uart_axis_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int PS    = 2;
  localparam int BIT   = 8 * PS;
`ifdef UART_AXIS_FIFO_PARITY_EN
  localparam int TB_PAR = 2;
`else
  localparam int TB_PAR = 0;
`endif
  localparam int NBITS = 10 + ((TB_PAR != 0) ? 1 : 0);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          rxd, txd;
  logic [15:0]   prescale = 16'(PS);
  logic          tx_busy, rx_busy;
  logic [LW-1:0] tx_level, rx_level;
  logic          rx_overrun, rx_frame_error, rx_parity_error;
  logic          tb_rxd = 1'b1;
  logic          loop_en = 1'b0;

  int n_cmp = 0, n_bad = 0;
  int ovr_cnt = 0, ferr_cnt = 0, perr_cnt = 0;

  assign rxd = loop_en ? txd : tb_rxd;

  uart_axis_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rxd(rxd), .txd(txd), .prescale(prescale),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_level(tx_level), .rx_level(rx_level),
    .rx_overrun(rx_overrun), .rx_frame_error(rx_frame_error), .rx_parity_error(rx_parity_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_overrun)      ovr_cnt++;
    if (rx_frame_error)  ferr_cnt++;
    if (rx_parity_error) perr_cnt++;
  end

  // Reference model: parity bit and the serial frame as a function of bit position.
  function automatic logic par_of(input logic [7:0] d);
    return (TB_PAR == 1) ? ~^d : ^d;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (TB_PAR != 0 && idx == 9) return par_of(d);
    return 1'b1;
  endfunction

  task automatic axis_push(input logic [7:0] d);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 1000) begin @(negedge clk); t++; end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL axis_push_ready: got %b expected 1", s_axis_tready); end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop, input logic pbit);
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)              tb_rxd = 1'b0;
      else if (b <= 8)         tb_rxd = d[b-1];
      else if (b == NBITS - 1) tb_rxd = stop;
      else                     tb_rxd = pbit;
      repeat (BIT) @(negedge clk);
    end
    tb_rxd = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 1'b1)           begin n_bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    n_cmp++; if ({tx_busy, rx_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b expected 00", {tx_busy, rx_busy}); end
    n_cmp++; if (tx_level !== '0 || rx_level !== '0) begin n_bad++; $display("FAIL reset_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
    n_cmp++; if ({rx_overrun, rx_frame_error, rx_parity_error} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {rx_overrun, rx_frame_error, rx_parity_error}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL post_reset_tready: got %b expected 1", s_axis_tready); end
  endtask

  // Push one byte and check txd every cycle against the frame model; prescale changes mid-frame.
  task automatic run_tx_frame(input logic [7:0] d, input int ps_exp, input logic [15:0] new_ps, input string name);
    int blen = 8 * ps_exp;
    int bad = 0;
    logic e;
    axis_push(d);
    n_cmp++; if (txd !== 1'b1 || tx_level !== LW'(1)) begin n_bad++; $display("FAIL %s_pre_start: got txd=%b level=%0d expected txd=1 level=1", name, txd, tx_level); end
    for (int k = 1; k <= NBITS * blen; k++) begin
      @(negedge clk);
      if (k == 20) prescale = new_ps;
      e = frame_bit(d, (k - 1) / blen);
      n_cmp++;
      if (txd !== e) begin
        n_bad++; bad++;
        if (bad < 5) $display("FAIL %s_txd cycle %0d: got %b expected %b", name, k, txd, e);
      end
    end
    @(negedge clk);
    n_cmp++; if (txd !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL %s_end: got txd=%b busy=%b expected txd=1 busy=0", name, txd, tx_busy); end
  endtask

  task automatic test_tx_frame();
    run_tx_frame(8'hA5, PS, 16'(PS), "tx_a5");
    prescale = 16'd0;
    run_tx_frame(8'($urandom), 1, 16'd7, "tx_ps0");
    prescale = 16'(PS);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] d, held, exp;
    bit stall = 1'b0;
    int got = 0;
    int base_o = ovr_cnt, base_f = ferr_cnt, base_p = perr_cnt;
    loop_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h55 : 8'($urandom);
      q.push_back(d);
      axis_push(d);
    end
    held = '0;
    for (int t = 0; t < 5000 && got < 8; t++) begin
      @(negedge clk);
      if (stall) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin n_bad++; $display("FAIL loop_hold: got valid=%b data=%h expected valid=1 data=%h", m_axis_tvalid, m_axis_tdata, held); end
      end
      m_axis_tready = 1'($urandom_range(0, 1));
      stall = m_axis_tvalid && !m_axis_tready;
      held  = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL loop_extra: got %h expected none", m_axis_tdata); end
        else begin
          exp = q.pop_front();
          if (m_axis_tdata !== exp) begin n_bad++; $display("FAIL loop_data %0d: got %h expected %h", got, m_axis_tdata, exp); end
        end
        got++;
      end
    end
    @(negedge clk);
    m_axis_tready = 1'b0;
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL loop_count: got %0d expected 8", got); end
    repeat (30) @(negedge clk);
    n_cmp++; if ({tx_busy, rx_busy} !== 2'b00) begin n_bad++; $display("FAIL loop_idle: got %b expected 00", {tx_busy, rx_busy}); end
    n_cmp++; if (ovr_cnt != base_o || ferr_cnt != base_f || perr_cnt != base_p) begin n_bad++; $display("FAIL loop_errors: got %0d/%0d/%0d expected 0/0/0", ovr_cnt - base_o, ferr_cnt - base_f, perr_cnt - base_p); end
    loop_en = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] q[$];
    logic [7:0] d, exp;
    int base_o = ovr_cnt;
    m_axis_tready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'($urandom);
      if (i < DEPTH) q.push_back(d);
      send_rx_frame(d, 1'b1, par_of(d));
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_level !== LW'(DEPTH)) begin n_bad++; $display("FAIL ovr_level: got %0d expected %0d", rx_level, DEPTH); end
    n_cmp++; if (ovr_cnt - base_o != 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - base_o); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = q.pop_front();
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin n_bad++; $display("FAIL ovr_data %0d: got valid=%b data=%h expected valid=1 data=%h", i, m_axis_tvalid, m_axis_tdata, exp); end
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    n_cmp++; if (rx_level !== '0 || m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL ovr_drained: got level=%0d valid=%b expected 0/0", rx_level, m_axis_tvalid); end
  endtask

  task automatic test_frame_error();
    logic [7:0] d;
    int base_f = ferr_cnt;
    send_rx_frame(8'h3C, 1'b0, par_of(8'h3C));
    repeat (20) @(negedge clk);
    n_cmp++; if (ferr_cnt - base_f != 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - base_f); end
    n_cmp++; if (rx_level !== '0 || m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL ferr_level: got level=%0d valid=%b expected 0/0", rx_level, m_axis_tvalid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_idle: got %b expected 0", rx_busy); end
    d = 8'($urandom);
    send_rx_frame(d, 1'b1, par_of(d));
    repeat (10) @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d) begin n_bad++; $display("FAIL ferr_recover: got valid=%b data=%h expected valid=1 data=%h", m_axis_tvalid, m_axis_tdata, d); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask

`ifdef UART_AXIS_FIFO_PARITY_EN
  task automatic test_parity();
    int base_p = perr_cnt;
    send_rx_frame(8'h01, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++; if (perr_cnt - base_p != 1) begin n_bad++; $display("FAIL par_pulse: got %0d expected 1", perr_cnt - base_p); end
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01) begin n_bad++; $display("FAIL par_data: got valid=%b data=%h expected valid=1 data=01", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    send_rx_frame(8'h03, 1'b1, par_of(8'h03));
    repeat (10) @(negedge clk);
    n_cmp++; if (perr_cnt - base_p != 1 || m_axis_tdata !== 8'h03) begin n_bad++; $display("FAIL par_good: got pulses=%0d data=%h expected 1/03", perr_cnt - base_p, m_axis_tdata); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_tx();
    logic [7:0] d0;
    int viol = 0;
    loop_en = 1'b1;
    d0 = 8'($urandom);
    axis_push(d0);
    axis_push(8'($urandom));
    axis_push(8'($urandom));
    repeat (86) @(negedge clk);
    n_cmp++; if (txd !== d0[4] || tx_level !== LW'(2)) begin n_bad++; $display("FAIL rstmid_pre: got txd=%b level=%0d expected txd=%b level=2", txd, tx_level, d0[4]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (txd !== 1'b1 || tx_level !== '0 || s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rstmid_now: got txd=%b level=%0d tready=%b expected 1/0/0", txd, tx_level, s_axis_tready); end
    n_cmp++; if (tx_busy !== 1'b0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b%b expected 00", tx_busy, rx_busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_level !== '0 || m_axis_tvalid !== 1'b0 || rx_level !== '0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", viol); end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_frame_error();
`ifdef UART_AXIS_FIFO_PARITY_EN
    test_parity();
`endif
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_axis_fifo.md
UART_AXIS_FIFO -- requirements
Module: uart_axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and per RX FIFO (power of 2, >=2).
REQ-003 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits sent (1 or 2).
REQ-005 SHALL have ports, one per line:
 clk  input  1  single clock for all logic
 rst  input  1  asynchronous, active-high reset
 s_axis_tdata  input  DATA_WIDTH  byte to transmit
 s_axis_tvalid  input  1  TX data valid
 s_axis_tready  output  1  TX FIFO not full
 m_axis_tdata  output  DATA_WIDTH  received byte
 m_axis_tvalid  output  1  RX FIFO not empty
 m_axis_tready  input  1  consumer accepts byte
 rxd  input  1  serial in, asynchronous, idle high
 txd  output  1  serial out, idle high
 prescale  input  16  clk cycles per 1/8 bit
 tx_busy  output  1  TX frame in progress or TX FIFO non-empty
 rx_busy  output  1  RX frame in progress
 tx_level  output  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
 rx_level  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
 rx_overrun  output  1  one-cycle pulse, byte dropped, RX FIFO full
 rx_frame_error  output  1  one-cycle pulse, stop bit sampled low
 rx_parity_error  output  1  one-cycle pulse, parity mismatch

Function
REQ-006 Bit period SHALL be 8*prescale clk cycles; prescale=0 SHALL be treated as 1; prescale SHALL be latched at frame start, changes mid-frame ignored.
REQ-007 AXI handshakes: transfer only when valid&&ready same rising edge; m_axis_tdata SHALL show RX FIFO head, stable while tvalid&&!tready.
REQ-008 TX FSM SHALL be IDLE->START->DATA->PARITY (PARITY!=0 only)->STOP->IDLE, LSB first, each state one bit period, STOP lasting STOP_BITS periods.
REQ-009 TX SHALL pop FIFO and drive start bit (txd=0) the cycle after IDLE with FIFO non-empty; back-to-back frames SHALL have no idle gap.
REQ-010 RX SHALL double-flop rxd; falling edge in IDLE enters START; start re-sampled low after 4*prescale cycles, else return to IDLE with no flags.
REQ-011 RX data, parity and stop bits SHALL be sampled every 8*prescale cycles after the start mid-sample; only one stop bit is checked.
REQ-012 Stop bit low SHALL pulse rx_frame_error, discard the byte, and wait for rxd high before re-entering IDLE.
REQ-013 Good stop bit SHALL push the byte into RX FIFO on the stop mid-sample cycle; m_axis_tvalid visible the next cycle.
REQ-014 RX FIFO full at push with no simultaneous pop SHALL drop the new byte, keep contents, pulse rx_overrun; push with simultaneous pop SHALL succeed, level unchanged.
REQ-015 Parity mismatch SHALL pulse rx_parity_error coincident with push; byte still pushed.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH; s_axis_tready=(tx_level!=FIFO_DEPTH).

Reset
REQ-017 rst asserted SHALL immediately force: txd=1, s_axis_tready=0 while asserted then 1, m_axis_tvalid=0, tx_busy=0, rx_busy=0, levels=0, all error pulses 0, FSMs IDLE.
REQ-018 Reset mid-frame SHALL abort the frame and flush both FIFOs; no partial byte delivered.

Configuration
REQ-019 With macro UART_AXIS_FIFO_PARITY_EN defined, parity generation/check per PARITY SHALL be built.
REQ-020 Without UART_AXIS_FIFO_PARITY_EN, PARITY SHALL be ignored (treated as 0), no parity bit sent/expected, rx_parity_error tied 0.

Verification
REQ-021 prescale=2, send 0xA5 via s_axis -> txd: start at cycle+1, bits 1,0,1,0,0,1,0,1, stop high, 16 clk each, 160 clk total.
REQ-022 Loop txd->rxd, push 0x00,0xFF,0x55 -> m_axis delivers same 3 bytes in order, no error pulses.
REQ-023 m_axis_tready=0, feed FIFO_DEPTH+1 frames -> rx_level=16, one rx_overrun pulse, first 16 bytes intact.
REQ-024 rxd frame 0x3C with stop bit low -> rx_frame_error pulse, rx_level stays 0.
REQ-025 Macro on, PARITY=2, rxd 0x01 with parity bit 0 -> rx_parity_error pulse, 0x01 delivered.
REQ-026 Assert rst mid-TX-data bit 4 with 3 bytes queued -> txd=1 same cycle, tx_level=0, no further frames.
